// File: rtl/adc_acq_sequencer.sv
// Burst acquisition sequencer for the LTC1746 driver: launches echo windows on acq_en
// and realigns the driver's delayed data_ready into tagged samples.
module adc_acq_sequencer #(
    parameter int ADC_WIDTH   = 14,
    parameter int ADC_LATENCY = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 SYS_CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CNT_WIDTH-1:0] init_delay,
    input  logic [CNT_WIDTH-1:0] samples_per_echo,
    input  logic [CNT_WIDTH-1:0] echo_count,
    input  logic [CNT_WIDTH-1:0] echo_gap,
    output logic                 acq_en,
    input  logic [ADC_WIDTH-1:0] adc_data,
    input  logic                 adc_ov,
    input  logic                 adc_dready,
    output logic [ADC_WIDTH-1:0] smp_data,
    output logic                 smp_valid,
    output logic                 smp_last,
    output logic [CNT_WIDTH-1:0] smp_echo,
    output logic                 ov_seen,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_DELAY, S_ACQ, S_GAP, S_FLUSH, S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0]   ONE       = 1;
    localparam logic [2*CNT_WIDTH-1:0] ONE_W     = 1;
    // One extra cycle beyond the driver latency so the last capture lands before DONE.
    localparam logic [CNT_WIDTH-1:0]   FLUSH_LEN = CNT_WIDTH'(ADC_LATENCY + 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_next_cnt;
    logic [CNT_WIDTH-1:0]   r_echo_left;
    logic [CNT_WIDTH-1:0]   w_next_echo_left;
    logic [CNT_WIDTH-1:0]   r_spe;
    logic [CNT_WIDTH-1:0]   r_gap;
    logic [2*CNT_WIDTH-1:0] r_total;
    logic                   w_accept;
    logic                   w_reject;
    logic                   r_rej_p0;
    logic                   r_cfg_err;
    logic                   r_acq_en;

    logic                   w_cap;
    logic                   w_win_end;
    logic [2*CNT_WIDTH-1:0] w_cap_total_nxt;
    logic [CNT_WIDTH-1:0]   r_cap_idx;
    logic [CNT_WIDTH-1:0]   r_cap_echo;
    logic [2*CNT_WIDTH-1:0] r_cap_total;
    logic [ADC_WIDTH-1:0]   r_smp_data;
    logic                   r_smp_valid;
    logic                   r_smp_last;
    logic [CNT_WIDTH-1:0]   r_smp_echo;
    logic                   r_ov_seen;

    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt;
        w_next_echo_left = r_echo_left;
        w_accept         = 1'b0;
        w_reject         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (samples_per_echo == '0 || echo_count == '0) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept         = 1'b1;
                        w_next_state     = S_DELAY;
                        w_next_cnt       = init_delay;
                        w_next_echo_left = echo_count - ONE;
                    end
                end
            end
            S_DELAY: begin
                if (abort) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = FLUSH_LEN;
                end else if (r_cnt == '0) begin
                    w_next_state = S_ACQ;
                    w_next_cnt   = r_spe - ONE;
                end else begin
                    w_next_cnt = r_cnt - ONE;
                end
            end
            S_ACQ: begin
                if (abort || (r_cnt == '0 && r_echo_left == '0)) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = FLUSH_LEN;
                end else if (r_cnt == '0) begin
                    // Zero gap keeps acq_en high straight into the next window.
                    w_next_echo_left = r_echo_left - ONE;
                    if (r_gap == '0) begin
                        w_next_cnt = r_spe - ONE;
                    end else begin
                        w_next_state = S_GAP;
                        w_next_cnt   = r_gap - ONE;
                    end
                end else begin
                    w_next_cnt = r_cnt - ONE;
                end
            end
            S_GAP: begin
                if (abort) begin
                    w_next_state = S_FLUSH;
                    w_next_cnt   = FLUSH_LEN;
                end else if (r_cnt == '0) begin
                    w_next_state = S_ACQ;
                    w_next_cnt   = r_spe - ONE;
                end else begin
                    w_next_cnt = r_cnt - ONE;
                end
            end
            S_FLUSH: begin
                if (r_cnt == '0) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_cnt = r_cnt - ONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_echo_left <= '0;
            r_spe       <= '0;
            r_gap       <= '0;
            r_total     <= '0;
            r_acq_en    <= 1'b0;
            r_rej_p0    <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_next_cnt;
            r_echo_left <= w_next_echo_left;
            r_acq_en    <= (w_next_state == S_ACQ);
            r_rej_p0    <= w_reject;
            r_cfg_err   <= r_rej_p0;
            if (w_accept) begin
                r_spe   <= samples_per_echo;
                r_gap   <= echo_gap;
                r_total <= (2*CNT_WIDTH)'(samples_per_echo) * (2*CNT_WIDTH)'(echo_count);
            end
        end
    end

    // Capture side: counts arriving samples independently of the launch counters.
    always_comb begin
        w_cap           = adc_dready && (r_state != S_IDLE);
        w_win_end       = (r_cap_idx == r_spe - ONE);
        w_cap_total_nxt = r_cap_total + ONE_W;
    end

    always_ff @(posedge SYS_CLK or posedge RESET) begin
        if (RESET) begin
            r_cap_idx   <= '0;
            r_cap_echo  <= '0;
            r_cap_total <= '0;
            r_smp_data  <= '0;
            r_smp_valid <= 1'b0;
            r_smp_last  <= 1'b0;
            r_smp_echo  <= '0;
            r_ov_seen   <= 1'b0;
        end else begin
            r_smp_valid <= w_cap;
            r_smp_last  <= w_cap && (w_cap_total_nxt == r_total);
            if (w_accept) begin
                r_cap_idx   <= '0;
                r_cap_echo  <= '0;
                r_cap_total <= '0;
                r_ov_seen   <= 1'b0;
            end else if (w_cap) begin
                r_smp_data  <= adc_data;
                r_smp_echo  <= r_cap_echo;
                r_cap_total <= w_cap_total_nxt;
                r_ov_seen   <= r_ov_seen | adc_ov;
                if (w_win_end) begin
                    r_cap_idx  <= '0;
                    r_cap_echo <= r_cap_echo + ONE;
                end else begin
                    r_cap_idx <= r_cap_idx + ONE;
                end
            end
        end
    end

    assign acq_en    = r_acq_en;
    assign smp_data  = r_smp_data;
    assign smp_valid = r_smp_valid;
    assign smp_last  = r_smp_last;
    assign smp_echo  = r_smp_echo;
    assign ov_seen   = r_ov_seen;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Bench for adc_acq_sequencer: an ADC driver model feeds the DUT and a per-cycle
// schedule model predicts every output from the burst configuration.
module tb_adc_acq_sequencer;

    localparam int AW   = 14;
    localparam int L    = 5;
    localparam int CW   = 16;
    localparam int MAXC = 80;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [CW-1:0] init_delay = '0;
    logic [CW-1:0] samples_per_echo = '0;
    logic [CW-1:0] echo_count = '0;
    logic [CW-1:0] echo_gap = '0;
    logic          acq_en;
    logic [AW-1:0] adc_data;
    logic          adc_ov;
    logic          adc_dready;
    logic [AW-1:0] smp_data;
    logic          smp_valid;
    logic          smp_last;
    logic [CW-1:0] smp_echo;
    logic          ov_seen;
    logic          busy;
    logic          done;
    logic          cfg_err;

    always #5 clk = ~clk;

    adc_acq_sequencer #(.ADC_WIDTH(AW), .ADC_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .SYS_CLK(clk), .RESET(rst), .start(start), .abort(abort),
        .init_delay(init_delay), .samples_per_echo(samples_per_echo),
        .echo_count(echo_count), .echo_gap(echo_gap), .acq_en(acq_en),
        .adc_data(adc_data), .adc_ov(adc_ov), .adc_dready(adc_dready),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_last(smp_last),
        .smp_echo(smp_echo), .ov_seen(ov_seen), .busy(busy), .done(done),
        .cfg_err(cfg_err)
    );

    function automatic logic [AW-1:0] pat(input int n);
        int v;
        v = (n * 1237 + 91) % 16384;
        return v[AW-1:0];
    endfunction

    // ADC driver model: each launch returns data_ready L cycles after acq_en.
    logic [L-1:0]  dv  = '0;
    logic [L-1:0]  dov = '0;
    logic [AW-1:0] dd [L] = '{default: '0};
    int            drv_n = 0;
    int            ov_launch = -1;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dv  <= {dv[L-2:0], acq_en};
        dov <= {dov[L-2:0], (acq_en && drv_n == ov_launch)};
        dd[0] <= acq_en ? pat(drv_n) : '0;
        for (int i = 1; i < L; i++) dd[i] <= dd[i-1];
        if (acq_en) drv_n <= drv_n + 1;
    end

    assign adc_dready = dv[L-1];
    assign adc_ov     = dov[L-1];
    assign adc_data   = dd[L-1];

    bit            e_busy [MAXC];
    bit            e_done [MAXC];
    bit            e_acq  [MAXC];
    bit            e_vld  [MAXC];
    bit            e_last [MAXC];
    bit            e_ov   [MAXC];
    bit            e_cfg  [MAXC];
    logic [AW-1:0] e_data [MAXC];
    int            e_echo [MAXC];

    int n_checks = 0;
    int n_fail   = 0;
    int seen_vld = 0;
    bit ov_prev  = 1'b0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, c, act, exp);
        end
    endtask

    task automatic compare_cycle(input int c);
        chk("acq_en", c, 32'(acq_en), 32'(e_acq[c]));
        chk("busy", c, 32'(busy), 32'(e_busy[c]));
        chk("done", c, 32'(done), 32'(e_done[c]));
        chk("cfg_err", c, 32'(cfg_err), 32'(e_cfg[c]));
        chk("smp_valid", c, 32'(smp_valid), 32'(e_vld[c]));
        chk("smp_last", c, 32'(smp_last), 32'(e_last[c]));
        chk("ov_seen", c, 32'(ov_seen), 32'(e_ov[c]));
        if (smp_valid === 1'b1) seen_vld++;
        if (e_vld[c]) begin
            chk("smp_data", c, 32'(smp_data), 32'(e_data[c]));
            chk("smp_echo", c, 32'(smp_echo), 32'(e_echo[c]));
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_acq_en"}, -1, 32'(acq_en), 0);
        chk({nm, "_smp_data"}, -1, 32'(smp_data), 0);
        chk({nm, "_smp_valid"}, -1, 32'(smp_valid), 0);
        chk({nm, "_smp_last"}, -1, 32'(smp_last), 0);
        chk({nm, "_smp_echo"}, -1, 32'(smp_echo), 0);
        chk({nm, "_ov_seen"}, -1, 32'(ov_seen), 0);
        chk({nm, "_busy"}, -1, 32'(busy), 0);
        chk({nm, "_done"}, -1, 32'(done), 0);
        chk({nm, "_cfg_err"}, -1, 32'(cfg_err), 0);
    endtask

    task automatic clear_model();
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_acq[c] = 0; e_vld[c] = 0;
            e_last[c] = 0; e_ov[c] = 0; e_cfg[c] = 0; e_data[c] = '0; e_echo[c] = 0;
        end
    endtask

    // Schedule model: window k of echo e launches at init_delay+1+e*(spe+gap)+k.
    task automatic build_model(input int sd, input int spe, input int ec, input int gap,
                               input int abort_at, input int ov_idx, input int base,
                               output int n_l, output int first, output int d_edge);
        int launch [$];
        int last_nat;
        bit aborted;
        int f_edge;
        clear_model();
        last_nat = 0;
        for (int e = 0; e < ec; e++) begin
            for (int k = 0; k < spe; k++) begin
                int t;
                t = sd + 1 + e * (spe + gap) + k;
                last_nat = t;
                if (abort_at < 0 || t < abort_at) launch.push_back(t);
            end
        end
        aborted = (abort_at >= 0) && (abort_at <= last_nat);
        f_edge  = aborted ? abort_at : last_nat + 1;
        d_edge  = f_edge + L + 2;
        n_l     = launch.size();
        first   = (n_l > 0) ? launch[0] : -1;
        for (int c = 0; c < MAXC; c++) begin
            e_busy[c] = (c <= d_edge);
            e_done[c] = (c == d_edge);
        end
        for (int j = 0; j < n_l; j++) begin
            int v;
            v = launch[j] + L + 1;
            e_acq[launch[j]] = 1;
            e_vld[v]  = 1;
            e_data[v] = pat(base + j);
            e_echo[v] = j / spe;
            e_last[v] = !aborted && (j == spe * ec - 1);
        end
        if (ov_idx >= 0 && ov_idx < n_l)
            for (int c = launch[ov_idx] + L + 1; c < MAXC; c++) e_ov[c] = 1;
    endtask

    task automatic run_burst(input int sd, input int spe, input int ec, input int gap,
                             input int abort_at, input int ov_idx, input int restart_at,
                             input int reset_at, output int n_l, output int first,
                             output int d_edge);
        int base;
        int clen;
        int vld0;
        @(negedge clk);
        base      = drv_n;
        ov_launch = (ov_idx >= 0) ? base + ov_idx : -1;
        build_model(sd, spe, ec, gap, abort_at, ov_idx, base, n_l, first, d_edge);
        clen = d_edge + 3;
        if (clen > MAXC) clen = MAXC;
        vld0 = seen_vld;
        init_delay = CW'(sd); samples_per_echo = CW'(spe);
        echo_count = CW'(ec); echo_gap = CW'(gap);
        start = 1'b1;
        for (int c = 0; c < clen; c++) begin
            @(negedge clk);
            if (c == 0) begin
                // Scrambled configuration must not affect a burst already launched.
                init_delay = 7; samples_per_echo = 0; echo_count = 0; echo_gap = 9;
            end
            start = (c + 1 == restart_at);
            abort = (c + 1 == abort_at);
            compare_cycle(c);
            if (c == reset_at) begin
                #2 rst = 1'b1;
                #1 check_all_zero("midreset");
                @(negedge clk);
                rst = 1'b0;
                abort = 1'b0;
                repeat (12) @(negedge clk);
                ov_prev = 1'b0;
                return;
            end
        end
        ov_prev = e_ov[clen-1];
        chk("sample_count", d_edge, 32'(seen_vld - vld0), 32'(n_l));
    endtask

    task automatic run_reject(input int spe, input int ec);
        clear_model();
        for (int c = 0; c < MAXC; c++) e_ov[c] = ov_prev;
        e_cfg[1] = 1;
        @(negedge clk);
        init_delay = 2; samples_per_echo = CW'(spe); echo_count = CW'(ec); echo_gap = 1;
        start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            compare_cycle(c);
            if (c == 1) chk("cfg_err_edge1", c, 32'(cfg_err), 1);
        end
    endtask

    initial begin
        int n_l, first, d_edge;
        #1 rst = 1'b1;
        #2 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_burst(3, 4, 2, 2, -1, -1, -1, -1, n_l, first, d_edge);
        chk("t1_first_launch", 0, 32'(first), 4);
        chk("t1_samples", 0, 32'(n_l), 8);
        chk("t1_done_edge", 0, 32'(d_edge), 21);

        run_burst(0, 3, 3, 0, -1, -1, -1, -1, n_l, first, d_edge);
        chk("t2_first_launch", 0, 32'(first), 1);
        chk("t2_samples", 0, 32'(n_l), 9);
        chk("t2_done_edge", 0, 32'(d_edge), 17);

        run_reject(0, 3);
        run_reject(4, 0);

        run_burst(1, 5, 2, 3, 12, -1, -1, -1, n_l, first, d_edge);
        chk("t4_samples", 0, 32'(n_l), 7);
        chk("t4_done_edge", 0, 32'(d_edge), 19);

        run_burst(2, 3, 2, 1, -1, 2, -1, -1, n_l, first, d_edge);
        run_burst(1, 2, 1, 0, -1, -1, -1, -1, n_l, first, d_edge);

        run_burst(2, 6, 2, 1, -1, -1, -1, 5, n_l, first, d_edge);
        run_burst(1, 4, 2, 1, -1, -1, 4, -1, n_l, first, d_edge);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_acq_sequencer.md
# adc_acq_sequencer

Acquisition sequencer that drives the `acq_en` input of the LTC1746 ADC driver and collects its output. It runs a programmed burst of echo windows: an initial delay, then `echo_count` windows of `samples_per_echo` samples each, separated by `echo_gap` idle cycles. It also realigns the driver's delayed `data_ready` against the windows, so every captured sample carries a valid flag, a last flag and an echo index. It sits between the pulse-sequence control logic and the acquisition FIFO/DMA.

## Interface
- ADC_WIDTH, 14, ADC sample width
- ADC_LATENCY, 5, driver data_ready delay in cycles; also the flush length
- CNT_WIDTH, 16, width of all configuration counters
- SYS_CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that launches a burst; ignored unless state is IDLE
- abort  in  1  level; terminates the burst early
- init_delay  in  CNT_WIDTH  cycles from start to the first window
- samples_per_echo  in  CNT_WIDTH  window length in samples
- echo_count  in  CNT_WIDTH  number of windows
- echo_gap  in  CNT_WIDTH  idle cycles between windows
- acq_en  out  1  registered; drives the driver's acq_en
- adc_data  in  ADC_WIDTH  driver Q_OUT
- adc_ov  in  1  driver Q_OUT_OV
- adc_dready  in  1  driver data_ready
- smp_data  out  ADC_WIDTH  captured sample
- smp_valid  out  1  one cycle per captured sample
- smp_last  out  1  with smp_valid on the final sample of the burst
- smp_echo  out  CNT_WIDTH  echo index (0-based) of smp_data
- ov_seen  out  1  sticky: any captured sample had adc_ov=1; cleared on start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at burst end
- cfg_err  out  1  one-cycle pulse when start is rejected

## Operation
- Configuration inputs are latched on an accepted start and ignored afterwards.
- An accepted start also clears ov_seen and all counters.
- start with samples_per_echo==0 or echo_count==0 is rejected: pulse cfg_err, stay in IDLE, acq_en is never raised.
- States:
  - IDLE: waiting for start.
  - DELAY: counts init_delay cycles. If init_delay==0 the FSM goes straight to ACQ.
  - ACQ: acq_en=1 for exactly samples_per_echo cycles. Then:
    - if echoes remain and echo_gap>0, go to GAP;
    - if echoes remain and echo_gap==0, start the next window immediately, so acq_en stays high with no dropout;
    - after the last window, go to FLUSH.
  - GAP: acq_en=0 for echo_gap cycles, then ACQ.
  - FLUSH: waits ADC_LATENCY+1 cycles so the delayed data_ready pipeline drains.
  - DONE: one cycle, done=1, then IDLE.
- Capture side: each cycle with adc_dready=1 registers adc_data into smp_data and raises smp_valid on the next cycle.
  - The capture counter tracks samples received and their echo index, independently of the launch counters.
  - smp_last is asserted when the captured-sample count reaches samples_per_echo*echo_count.
  - adc_dready outside a burst (state IDLE) is ignored.
  - adc_ov on a captured sample sets ov_seen.
- abort in DELAY, ACQ or GAP: acq_en falls on the next edge and the FSM enters FLUSH. In-flight samples are still emitted; smp_last is not asserted. abort in FLUSH, DONE or IDLE has no effect.
- start during busy is ignored: no cfg_err, no restart.

## Timing
- Reset values: acq_en=0, smp_data=0, smp_valid=0, smp_last=0, smp_echo=0, ov_seen=0, busy=0, done=0, cfg_err=0; state IDLE.
- Cycle numbering: start is sampled at edge 0, and busy=1 from edge 0.
- acq_en first rises at edge init_delay+1 and stays high for exactly samples_per_echo edges.
- Next window rises echo_gap cycles after the previous fall.
- Sample k leaves the driver with data_ready at launch edge + ADC_LATENCY, so smp_valid for sample k appears ADC_LATENCY+1 cycles after acq_en was high for it.
- done occurs ADC_LATENCY+2 cycles after the final acq_en fall; busy falls with the return to IDLE on the edge after done.
- cfg_err is asserted at edge 1 for a rejected start.
- Counter widths: the total-sample product is computed in 2*CNT_WIDTH bits, so there is no wrap.
- RESET asserted mid-burst: all outputs are forced to reset values immediately; no done pulse.

## Test plan
- init_delay=3, samples_per_echo=4, echo_count=2, echo_gap=2 -> acq_en high at edges 4-7 and 10-13, 8 smp_valid pulses with smp_echo 0×4 then 1×4, smp_last on the 8th, done one pulse later plus flush.
- echo_gap=0, samples_per_echo=3, echo_count=3, init_delay=0 -> acq_en continuous for 9 cycles starting edge 1, 9 samples, smp_echo increments every 3.
- samples_per_echo=0 -> cfg_err at edge 1, acq_en never high, busy stays 0; echo_count=0 behaves the same.
- abort asserted 2 cycles into the second window of 2×5 -> acq_en drops next edge, 7 samples emitted, smp_last never asserted, done after flush.
- adc_ov=1 on sample 3 only -> ov_seen rises with that sample's smp_valid and holds; the next start clears it.
- RESET pulsed mid-ACQ -> all outputs 0 asynchronously; a later start runs a clean full burst; start pulsed while busy is ignored.
